// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns datapath load/store requests into handshaked memory
// accesses, stalling the core while an access is in flight.
module lsu_mem_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic        fault,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   waddr_q, waddr_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   lane_q, lane_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          to_q, to_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          illegal, misalign, req_go, req_fault, tmo;
   logic [CW:0]   cnt_inc;
   logic [3:0]    be_req;
   logic [31:0]   lane_req, shifted, load_ext;

   // Request decode; reset masks the request so nothing leaks out while rst is low.
   always_comb begin
      unique case (func3)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = req_we;
         default:                illegal = 1'b1;
      endcase
      misalign  = ((func3[1:0] == 2'b01) && addr[0]) ||
                  ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      req_go    = rst && req_valid && !illegal && !misalign;
      req_fault = rst && req_valid && (illegal || misalign);

      unique case (func3[1:0])
         2'b00: begin
            be_req   = 4'b0001 << addr[1:0];
            lane_req = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_req   = 4'b0011 << {addr[1], 1'b0};
            lane_req = {2{wdata[15:0]}};
         end
         default: begin
            be_req   = 4'b1111;
            lane_req = wdata;
         end
      endcase
   end

   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      unique case (f3_q)
         3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_ext = {24'h0, shifted[7:0]};
         3'b101:  load_ext = {16'h0, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   // Timeout fires on the TIMEOUT-th ACCESS cycle without ack.
   always_comb begin
      cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);
      tmo     = cnt_inc >= (CW + 1)'(TIMEOUT);
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_go) state_d = ACCESS;
         ACCESS:  if (mem_ack || tmo) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req   = (state_q == ACCESS);
      mem_we    = (state_q == ACCESS) && we_q;
      stall     = ((state_q == IDLE) && req_go) || (state_q == ACCESS);
      done      = (state_q == DONE);
      fault     = ((state_q == IDLE) && req_fault) || ((state_q == DONE) && to_q);
      rdata     = rdata_q;
      mem_addr  = waddr_q;
      mem_wdata = lane_q;
      mem_be    = be_q;
   end

   always_comb begin
      we_d    = we_q;
      f3_d    = f3_q;
      off_d   = off_q;
      waddr_d = waddr_q;
      be_d    = be_q;
      lane_d  = lane_q;
      rdata_d = rdata_q;
      to_d    = to_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_go) begin
               we_d    = req_we;
               f3_d    = func3;
               off_d   = addr[1:0];
               waddr_d = {addr[31:2], 2'b00};
               be_d    = be_req;
               lane_d  = lane_req;
               to_d    = 1'b0;
               cnt_d   = '0;
            end
         end
         ACCESS: begin
            cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_inc[CW-1:0];
            if (mem_ack) begin
               rdata_d = we_q ? '0 : load_ext;
            end else if (tmo) begin
               rdata_d = '0;
               to_d    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         we_q    <= 1'b0;
         f3_q    <= '0;
         off_q   <= '0;
         waddr_q <= '0;
         be_q    <= '0;
         lane_q  <= '0;
         rdata_q <= '0;
         to_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         we_q    <= we_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         waddr_q <= waddr_d;
         be_q    <= be_d;
         lane_q  <= lane_d;
         rdata_q <= rdata_d;
         to_q    <= to_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store unit between the single-cycle datapath and a handshaked data memory. It sits downstream of the datapath's address/store-data outputs (ALUResult, RD2) and upstream of the Result mux. It performs byte, halfword and word accesses with sign or zero extension, and holds the core with `stall` while a memory access with variable latency is in flight. It detects misaligned addresses, illegal `func3` codes and memory timeouts.

## Interface
- `TIMEOUT`, default 255: maximum number of ACCESS cycles without `mem_ack` before the access is abandoned; must be ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  current instruction is a load/store.
- `req_we`  in  1  1 = store, 0 = load.
- `func3`  in  3  instr[14:12]: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr`  in  32  byte address (ALUResult).
- `wdata`  in  32  store data (RD2).
- `stall`  out  1  hold PC and register-file writes.
- `done`  out  1  one-cycle pulse; access complete, `rdata` valid.
- `fault`  out  1  one-cycle pulse on misalignment, illegal func3 or timeout.
- `rdata`  out  32  extended load result to the Result mux.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_ack`  in  1  memory accepted the write or returned read data this cycle.
- `mem_rdata`  in  32  read word; valid when `mem_ack`=1.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE:**
  - On `req_valid` with a legal, aligned request:
    - `stall`=1 combinationally.
    - Capture `req_we`, `func3`, `addr[1:0]`, word address, byte enables and lane data.
    - Clear the timeout counter.
    - Next state: ACCESS.
  - On `req_valid` with a fault:
    - `fault`=1 and `stall`=0 in the same cycle.
    - No memory request is issued. State stays IDLE.
  - Faults:
    - Illegal func3: 011, 110, 111, and also 100 or 101 with `req_we`=1.
    - Misaligned halfword: `addr[0]`=1.
    - Misaligned word: `addr[1:0]`≠0.
- **ACCESS:**
  - `mem_req`=1 and `stall`=1.
  - `mem_addr`, `mem_we`, `mem_wdata` and `mem_be` stay stable from the captured registers.
  - `mem_ack`=1: latch the load result into `rdata` (stores load 0), then go to DONE.
  - Counter reaches `TIMEOUT` without ack: `rdata`←0, set the timeout flag, go to DONE.
- **DONE:**
  - `done`=1 and `stall`=0, so the core advances on this edge.
  - `fault`=1 if the timeout flag is set.
  - `req_valid` is ignored in this state; it still reflects the completed instruction.
  - Next state: IDLE.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
  - Loads drive the same mask with `mem_we`=0.
- Store lanes:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extract: shift = mem_rdata >> (8·addr[1:0]).
  - LB/LH: sign-extend bit 7 or bit 15.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- `rdata` holds its value until the next DONE or reset.
- `mem_ack` is ignored in IDLE and DONE.

## Timing
- Reset (`rst`=0 at an edge):
  - State IDLE.
  - `stall`, `done`, `fault`, `mem_req`, `mem_we` = 0.
  - `rdata`, `mem_addr`, `mem_wdata` = 0; `mem_be`=4'b0000.
  - Counter 0.
- Reset during ACCESS: the access is abandoned and `mem_req` is 0 in the cycle after the reset edge. No `done` is produced.
- Latency with N wait states (ack in the (N+1)th ACCESS cycle): `done` appears in cycle N+2 after the request cycle. The instruction occupies N+3 cycles in total.
- With zero wait states, `mem_ack` is sampled in the first ACCESS cycle.
- Timeout: `done` and `fault` appear TIMEOUT+1 cycles after ACCESS entry.
- `stall` is never 1 in DONE. `done` and `stall` are never both 1.
- Counter width is $clog2(TIMEOUT+1) and it saturates; no wrap-around.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `req_valid`=1 → all outputs 0, `mem_req` never 1. Release reset → the access starts in the following cycle.
- LB, addr=0x1003, ack in the first ACCESS cycle, mem_rdata=0x80FF1234:
  - `mem_addr`=0x1000, `mem_be`=4'b1000.
  - `rdata`=0xFFFFFF80 with `done` 2 cycles after the request.
- LHU, addr=0x2002, 3 wait states, mem_rdata=0xBEEF0000:
  - `mem_req` is high for 4 cycles with the address stable.
  - `rdata`=0x0000BEEF, `done` in cycle 5.
- SB, addr=0x10, wdata=0x12345678:
  - `mem_we`=1, `mem_be`=4'b0001, `mem_wdata`=0x78787878.
  - `rdata`=0 at `done`.
- Faults:
  - SW at addr=0x6 → `fault`=1, `stall`=0 in the same cycle, `mem_req` stays 0.
  - func3=3'b011 → same response.
- Timeout and abort:
  - TIMEOUT=4, ack never asserted → `mem_req` high for 4 cycles, then `done`=`fault`=1, `rdata`=0.
  - Second access with `rst`=0 during its 2nd ACCESS cycle → `mem_req`=0 in the next cycle, no `done`.
